// File: rtl/vfd_scan_if.sv
// vfd_scan_if -- control/status bundle between the VFD scan sequencer and
// the blocks it steers (Tri-SPI shifter, GCP generator, panel pins, host).
//
// Signals:
//   EN          host -> seq   run request
//   HOLD        host -> seq   freeze scan at the next frame boundary
//   HOLD_ACK    seq  -> host  scan frozen, display RAM safe to write
//   SCE         seq  -> TSPI  shift enable
//   PCE         seq  -> GCP   grid-clock generator enable
//   GN[5:0]     seq  -> TSPI  grid number of the line being shifted
//   BIT_CNT[8:0] seq -> TSPI  bit index within the line shift
//   BLK, LAT    seq  -> panel blanking and serial latch pins
//   FRAME_START seq  -> host  one-cycle pulse on the first shift cycle of grid 0
//   BUSY        seq  -> host  sequencer is not idle
//
// Modports: master = the sequencer, slave = the host/panel side.
interface vfd_scan_if;
  logic       EN;
  logic       HOLD;
  logic       HOLD_ACK;
  logic       SCE;
  logic       PCE;
  logic [5:0] GN;
  logic [8:0] BIT_CNT;
  logic       BLK;
  logic       LAT;
  logic       FRAME_START;
  logic       BUSY;

  modport master (
    input  EN, HOLD,
    output HOLD_ACK, SCE, PCE, GN, BIT_CNT, BLK, LAT, FRAME_START, BUSY
  );

  modport slave (
    output EN, HOLD,
    input  HOLD_ACK, SCE, PCE, GN, BIT_CNT, BLK, LAT, FRAME_START, BUSY
  );
endinterface

// File: rtl/vfd_scan_sequencer.sv
// vfd_scan_sequencer -- line/frame scheduler for the MN15439A VFD path.
//
// Each line: SHIFT (SCE high for SHIFT_BITS cycles), BSET (blank before the
// latch), LATCH (LAT pulse), BHOLD (blank after the latch), then WAIT until
// the line period is used up. At the end of every line EN and, at the end of
// a frame, HOLD decide whether scanning continues. All outputs are registered.
//
// Ports:
//   CLK   system clock (12 MHz)
//   RST   synchronous reset, active-high
//   scan  vfd_scan_if.master -- EN/HOLD in; HOLD_ACK, SCE, PCE, GN, BIT_CNT,
//         BLK, LAT, FRAME_START, BUSY out
//
// BLK_SETUP, LAT_WIDTH and BLK_HOLD must each be at least 1, and LINE_PERIOD
// must leave at least one WAIT cycle after BHOLD.
module vfd_scan_sequencer #(
  parameter int NUM_GRIDS   = 52,
  parameter int SHIFT_BITS  = 288,
  parameter int BLK_SETUP   = 1,
  parameter int LAT_WIDTH   = 5,
  parameter int BLK_HOLD    = 1,
  parameter int LINE_PERIOD = 320
) (
  input  logic       CLK,
  input  logic       RST,
  vfd_scan_if.master scan
);

  localparam int LC_W = $clog2(LINE_PERIOD);
  typedef logic [LC_W-1:0] lc_t;

  // Last line-counter value of each phase within a line.
  localparam lc_t SHIFT_LAST = lc_t'(SHIFT_BITS - 1);
  localparam lc_t BSET_LAST  = lc_t'(SHIFT_BITS + BLK_SETUP - 1);
  localparam lc_t LATCH_LAST = lc_t'(SHIFT_BITS + BLK_SETUP + LAT_WIDTH - 1);
  localparam lc_t BHOLD_LAST = lc_t'(SHIFT_BITS + BLK_SETUP + LAT_WIDTH + BLK_HOLD - 1);
  localparam lc_t LINE_LAST  = lc_t'(LINE_PERIOD - 1);
  localparam logic [5:0] GN_LAST = 6'(NUM_GRIDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BSET,
    S_LATCH,
    S_BHOLD,
    S_WAIT
  } state_t;

  state_t     state_q, state_d;
  lc_t        lc_q, lc_d;
  logic [5:0] gn_q, gn_d;
  logic       line_valid_q, line_valid_d;

  logic       sce_q, sce_d;
  logic       pce_q, pce_d;
  logic [8:0] bit_cnt_q, bit_cnt_d;
  logic       blk_q, blk_d;
  logic       lat_q, lat_d;
  logic       frame_start_q, frame_start_d;
  logic       hold_ack_q, hold_ack_d;
  logic       busy_q, busy_d;

  // Next state, line counter, grid number and line_valid.
  always_comb begin
    // NOTE: every signal of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    lc_d         = (state_q == S_IDLE) ? lc_q : lc_q + 1'b1;
    gn_d         = gn_q;
    line_valid_d = line_valid_q;

    case (state_q)
      S_IDLE: begin
        if (scan.EN && !scan.HOLD) begin
          state_d = S_SHIFT;
          lc_d    = '0;
          gn_d    = '0;
        end
      end
      S_SHIFT: if (lc_q == SHIFT_LAST) state_d = S_BSET;
      S_BSET:  if (lc_q == BSET_LAST)  state_d = S_LATCH;
      S_LATCH: begin
        // The line just shifted is now in the panel latches, so the next
        // line may drive the grid clock.
        line_valid_d = 1'b1;
        if (lc_q == LATCH_LAST) state_d = S_BHOLD;
      end
      S_BHOLD: if (lc_q == BHOLD_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (lc_q == LINE_LAST) begin
          lc_d = '0;
          if (!scan.EN || (gn_q == GN_LAST && scan.HOLD)) begin
            state_d      = S_IDLE;
            gn_d         = '0;
            line_valid_d = 1'b0;
          end else begin
            state_d = S_SHIFT;
            gn_d    = (gn_q == GN_LAST) ? 6'd0 : gn_q + 6'd1;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        lc_d         = '0;
        gn_d         = '0;
        line_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    sce_d         = (state_d == S_SHIFT);
    pce_d         = sce_d && line_valid_d;
    bit_cnt_d     = sce_d ? 9'(lc_d) : 9'd0;
    blk_d         = (state_d inside {S_IDLE, S_BSET, S_LATCH, S_BHOLD});
    lat_d         = (state_d == S_LATCH);
    // Only IDLE->SHIFT or a grid wrap enters SHIFT with grid 0.
    frame_start_d = sce_d && (state_q != S_SHIFT) && (gn_d == 6'd0);
    hold_ack_d    = (state_d == S_IDLE) && scan.HOLD;
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (RST) begin
      state_q       <= S_IDLE;
      lc_q          <= '0;
      gn_q          <= '0;
      line_valid_q  <= 1'b0;
      sce_q         <= 1'b0;
      pce_q         <= 1'b0;
      bit_cnt_q     <= '0;
      blk_q         <= 1'b1;
      lat_q         <= 1'b0;
      frame_start_q <= 1'b0;
      hold_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lc_q          <= lc_d;
      gn_q          <= gn_d;
      line_valid_q  <= line_valid_d;
      sce_q         <= sce_d;
      pce_q         <= pce_d;
      bit_cnt_q     <= bit_cnt_d;
      blk_q         <= blk_d;
      lat_q         <= lat_d;
      frame_start_q <= frame_start_d;
      hold_ack_q    <= hold_ack_d;
      busy_q        <= busy_d;
    end
  end

  assign scan.SCE         = sce_q;
  assign scan.PCE         = pce_q;
  assign scan.GN          = gn_q;
  assign scan.BIT_CNT     = bit_cnt_q;
  assign scan.BLK         = blk_q;
  assign scan.LAT         = lat_q;
  assign scan.FRAME_START = frame_start_q;
  assign scan.HOLD_ACK    = hold_ack_q;
  assign scan.BUSY        = busy_q;

endmodule

// File: tb/tb_vfd_scan_sequencer.sv
// tb_vfd_scan_sequencer -- bench for vfd_scan_sequencer with default parameters.
// A line-position model predicts the outputs for every cycle at the clock edge
// and queues them; the falling-edge checker pops and compares. Directed checks
// cover the first line, two full frames, HOLD at a frame end, EN dropped
// mid-line and RST during the latch pulse; a monitor watches the safety rules.
module tb_vfd_scan_sequencer;
  localparam int NUM_GRIDS   = 52;
  localparam int SHIFT_BITS  = 288;
  localparam int BLK_SETUP   = 1;
  localparam int LAT_WIDTH   = 5;
  localparam int BLK_HOLD    = 1;
  localparam int LINE_PERIOD = 320;
  localparam int FRAME       = NUM_GRIDS * LINE_PERIOD;
  localparam int BLK_FIRST   = SHIFT_BITS;
  localparam int LAT_FIRST   = SHIFT_BITS + BLK_SETUP;
  localparam int LAT_LAST    = LAT_FIRST + LAT_WIDTH - 1;
  localparam int BLK_LAST    = LAT_LAST + BLK_HOLD;

  typedef struct packed {
    logic       hold_ack;
    logic       sce;
    logic       pce;
    logic [5:0] gn;
    logic [8:0] bit_cnt;
    logic       blk;
    logic       lat;
    logic       fs;
    logic       busy;
  } outs_t;

  logic CLK = 1'b0;
  logic RST;
  vfd_scan_if bus ();

  vfd_scan_sequencer dut (
    .CLK  (CLK),
    .RST  (RST),
    .scan (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.hold_ack = bus.HOLD_ACK;
    o.sce      = bus.SCE;
    o.pce      = bus.PCE;
    o.gn       = bus.GN;
    o.bit_cnt  = bus.BIT_CNT;
    o.blk      = bus.BLK;
    o.lat      = bus.LAT;
    o.fs       = bus.FRAME_START;
    o.busy     = bus.BUSY;
    return o;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  bit    m_run = 1'b0, m_valid = 1'b0, m_hack = 1'b0, m_fs = 1'b0;
  int    m_pos = 0, m_gn = 0;
  outs_t m_e;
  outs_t exp_q[$];

  always @(posedge CLK) begin : model
    if (RST) begin
      m_run = 1'b0; m_pos = 0; m_gn = 0; m_valid = 1'b0; m_hack = 1'b0; m_fs = 1'b0;
    end else if (!m_run) begin
      m_fs = 1'b0;
      if (bus.EN && !bus.HOLD) begin
        m_run = 1'b1; m_pos = 0; m_gn = 0; m_fs = 1'b1;
      end
      m_hack = bus.HOLD && !m_run;
    end else begin
      m_fs   = 1'b0;
      m_hack = 1'b0;
      if (m_pos == LINE_PERIOD - 1) begin
        m_pos = 0;
        if (!bus.EN || (m_gn == NUM_GRIDS - 1 && bus.HOLD)) begin
          m_run = 1'b0; m_gn = 0; m_valid = 1'b0; m_hack = bus.HOLD;
        end else if (m_gn == NUM_GRIDS - 1) begin
          m_gn = 0; m_fs = 1'b1;
        end else begin
          m_gn++;
        end
      end else begin
        m_pos++;
        if (m_pos == LAT_FIRST) m_valid = 1'b1;
      end
    end

    m_e = '0;
    if (m_run) begin
      m_e.sce     = (m_pos < SHIFT_BITS);
      m_e.pce     = m_e.sce && m_valid;
      m_e.gn      = 6'(m_gn);
      m_e.bit_cnt = m_e.sce ? 9'(m_pos) : 9'd0;
      m_e.blk     = (m_pos >= BLK_FIRST) && (m_pos <= BLK_LAST);
      m_e.lat     = (m_pos >= LAT_FIRST) && (m_pos <= LAT_LAST);
      m_e.fs      = m_fs;
      m_e.busy    = 1'b1;
    end else begin
      m_e.blk      = 1'b1;
      m_e.hold_ack = m_hack;
    end
    exp_q.push_back(m_e);
  end

  outs_t sb_o, sb_e;
  always @(negedge CLK) begin : scoreboard
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      sb_o = sample();
      // The bit index only has meaning while shifting.
      if (sb_e.busy && !sb_e.sce) sb_o.bit_cnt = sb_e.bit_cnt;
      check("outs", 32'(sb_o), 32'(sb_e));
    end
  end

  // ---------------- safety monitor ----------------
  logic sce_p = 1'b0, lat_p = 1'b0;
  int   sce_len = 0, lat_len = 0, blk_run = 0;
  always @(negedge CLK) begin : monitor
    if (!RST) begin
      check("sce_and_lat", 32'(bus.SCE & bus.LAT), 32'd0);
      check("gn_range", 32'(bus.GN > 6'(NUM_GRIDS - 1)), 32'd0);
      if (bus.LAT && !lat_p) check("blk_before_lat", 32'(blk_run >= BLK_SETUP), 32'd1);
      // A pulse ending with BUSY low was cut short by reset.
      if (!bus.SCE && sce_p && bus.BUSY) check("sce_len", 32'(sce_len), 32'(SHIFT_BITS));
      if (!bus.LAT && lat_p && bus.BUSY) check("lat_width", 32'(lat_len), 32'(LAT_WIDTH));
    end
    sce_len = bus.SCE ? sce_len + 1 : 0;
    lat_len = bus.LAT ? lat_len + 1 : 0;
    blk_run = bus.BLK ? blk_run + 1 : 0;
    sce_p   = bus.SCE;
    lat_p   = bus.LAT;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_shift(input int g, input int b, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLK);
      if (bus.SCE && bus.GN == 6'(g) && bus.BIT_CNT == 9'(b)) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) begin
        found = 1'b1;
        n = i;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  outs_t rst_exp;
  int    fs_n, fs_first, fs_second, lines, pce_lines, n_idle;
  logic  sce_was;
  bit    got_lat;

  initial begin
    RST = 1'b1; bus.EN = 1'b0; bus.HOLD = 1'b0;
    repeat (3) @(negedge CLK);
    rst_exp = '0;
    rst_exp.blk = 1'b1;
    check("reset_outs", 32'(sample()), 32'(rst_exp));

    // Cycle 0: reset released with EN high.
    RST = 1'b0; bus.EN = 1'b1;
    fs_n = 0; fs_first = 0; fs_second = 0; lines = 0; pce_lines = 0; sce_was = 1'b0;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge CLK);
      if (bus.FRAME_START) begin
        fs_n++;
        if (fs_n == 1) fs_first = c; else fs_second = c;
      end
      if (bus.SCE && !sce_was) begin
        check("gn_seq", 32'(bus.GN), 32'(lines % NUM_GRIDS));
        lines++;
        if (bus.PCE) pce_lines++;
      end
      sce_was = bus.SCE;
      if (c == 1) begin
        check("c1_sce", 32'(bus.SCE), 32'd1);
        check("c1_fs", 32'(bus.FRAME_START), 32'd1);
        check("c1_pce", 32'(bus.PCE), 32'd0);
        check("c1_bit", 32'(bus.BIT_CNT), 32'd0);
      end
      if (c == 288) check("c288_bit", 32'(bus.BIT_CNT), 32'd287);
      if (c == 289) check("c289_sce_blk_lat", {bus.SCE, bus.BLK, bus.LAT}, 32'b010);
      if (c == 290) check("c290_lat", 32'(bus.LAT), 32'd1);
      if (c == 294) check("c294_lat", 32'(bus.LAT), 32'd1);
      if (c == 295) check("c295_blk_lat", {bus.BLK, bus.LAT}, 32'b10);
      if (c == 296) check("c296_blk", 32'(bus.BLK), 32'd0);
      if (c == 321) check("c321_sce_gn_pce", {bus.SCE, 2'b00, bus.GN, bus.PCE}, {1'b1, 2'b00, 6'd1, 1'b1});
    end
    check("fs_count", 32'(fs_n), 32'd2);
    check("fs_first", 32'(fs_first), 32'd1);
    check("fs_spacing", 32'(fs_second - fs_first), 32'(FRAME));
    check("line_count", 32'(lines), 32'(2 * NUM_GRIDS));
    check("pce_lines", 32'(pce_lines), 32'(2 * NUM_GRIDS - 1));

    // HOLD raised during grid 20: grids 20..51 finish, then IDLE.
    wait_shift(20, 0, FRAME, "wait_gn20");
    bus.HOLD = 1'b1;
    wait_idle(FRAME, "hold_idle_timeout", n_idle);
    check("hold_latency", 32'(n_idle), 32'((NUM_GRIDS - 20) * LINE_PERIOD));
    check("hold_ack", 32'(bus.HOLD_ACK), 32'd1);
    check("hold_blk_gn", {bus.BLK, 2'b00, bus.GN}, {1'b1, 2'b00, 6'd0});
    repeat (5) @(negedge CLK);
    check("hold_stay", {bus.BUSY, bus.HOLD_ACK}, 32'b01);
    bus.HOLD = 1'b0;
    @(negedge CLK);
    check("release_sce_fs_ack", {bus.SCE, bus.FRAME_START, bus.HOLD_ACK}, 32'b110);
    check("release_gn", 32'(bus.GN), 32'd0);

    // EN dropped at bit 100 of grid 7: the line completes, then IDLE.
    wait_shift(7, 100, 8 * LINE_PERIOD, "wait_gn7");
    bus.EN = 1'b0;
    wait_idle(2 * LINE_PERIOD, "en_idle_timeout", n_idle);
    check("en_drop_latency", 32'(n_idle), 32'(LINE_PERIOD - 100));
    check("en_drop_gn_blk", {bus.BLK, 2'b00, bus.GN}, {1'b1, 2'b00, 6'd0});

    // RST during the second LAT cycle.
    bus.EN = 1'b1;
    got_lat = 1'b0;
    for (int i = 0; i < 2 * LINE_PERIOD && !got_lat; i++) begin
      @(negedge CLK);
      if (bus.LAT) got_lat = 1'b1;
    end
    check("wait_lat", 32'(got_lat), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_lat_blk_sce_busy", {bus.LAT, bus.BLK, bus.SCE, bus.BUSY}, 32'b0100);
    check("rst_gn", 32'(bus.GN), 32'd0);
    RST = 1'b0; bus.EN = 1'b0;
    repeat (5) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
